// File: rtl/logic_exec_unit.sv
// logic_exec_unit: multi-cycle executor for the nibble logical instructions
// AND / OR / XOR / FAN (FAN = AND that only updates Z).
// Operands come from A, B, M(X), M(Y) or an immediate. Every instruction takes
// exactly CYCLES enabled cycles, counting the start cycle.
// Optional build feature: define LOGIC_EXEC_OPCOUNT_EN to add a saturating
// 16-bit op_count output that counts committed instructions.
//
// Handshake: start is taken only in IDLE on a clk_en-high edge, and the
// operands are snapshotted on that edge. busy is high from the next cycle
// through the COMMIT cycle. done pulses for exactly the COMMIT cycle. start
// while busy is dropped, not queued. While clk_en is low, state and strobes
// hold, so every strobe must be qualified with clk_en by the consumer.
module logic_exec_unit #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int CYCLES     = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [1:0]            dst_sel,
  input  logic [1:0]            src_sel,
  input  logic                  src_imm,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [ADDR_WIDTH-1:0] x_in,
  input  logic [ADDR_WIDTH-1:0] y_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  a_we,
  output logic                  b_we,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  zero_we,
  output logic                  zero_out,
  output logic                  busy,
  output logic                  done
`ifdef LOGIC_EXEC_OPCOUNT_EN
  ,
  output logic [15:0]           op_count
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_DST  = 3'd1;
  localparam logic [2:0] ST_RD_SRC  = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_PAD     = 3'd4;
  localparam logic [2:0] ST_COMMIT  = 3'd5;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_FAN = 2'd3;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;

  // cnt value of the COMMIT cycle
  localparam logic [3:0] LAST_CNT = 4'(CYCLES - 1);

  // Five cycles is the minimum with fixed read slots; 15 is the 4-bit counter limit.
  generate
    if (CYCLES < 5 || CYCLES > 15) begin : g_cycles_out_of_range
      $error("logic_exec_unit: CYCLES must be in 5..15");
    end
  endgenerate

  logic [2:0]            r_state;
  logic [3:0]            r_cnt;
  logic [1:0]            r_op;
  logic [1:0]            r_dst_sel;
  logic [1:0]            r_src_sel;
  logic                  r_src_imm;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [ADDR_WIDTH-1:0] r_x;
  logic [ADDR_WIDTH-1:0] r_y;
  logic [DATA_WIDTH-1:0] r_dst_val;
  logic [DATA_WIDTH-1:0] r_result;

  logic                  w_dst_mem;
  logic                  w_src_mem;
  logic [ADDR_WIDTH-1:0] w_dst_addr;
  logic [ADDR_WIDTH-1:0] w_src_addr;
  logic [DATA_WIDTH-1:0] w_dst_reg;
  logic [DATA_WIDTH-1:0] w_src_reg;
  logic [DATA_WIDTH-1:0] w_dst_now;
  logic [DATA_WIDTH-1:0] w_src_now;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [3:0]            w_next_cnt;

  // Selector bit 1 means memory, bit 0 picks B over A or Y over X.
  assign w_dst_mem  = r_dst_sel[1];
  assign w_src_mem  = r_src_sel[1] & ~r_src_imm;
  assign w_dst_addr = r_dst_sel[0] ? r_y : r_x;
  assign w_src_addr = r_src_sel[0] ? r_y : r_x;
  assign w_dst_reg  = r_dst_sel[0] ? r_b : r_a;
  assign w_src_reg  = r_src_sel[0] ? r_b : r_a;
  assign w_dst_now  = w_dst_mem ? mem_rdata : w_dst_reg;
  assign w_src_now  = r_src_imm ? r_imm : (r_src_sel[1] ? mem_rdata : w_src_reg);
  assign w_next_cnt = r_cnt + 4'd1;

  // Bitwise operation at full width; FAN is an AND whose result is never written back.
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_AND:  w_alu = r_dst_val & w_src_now;
      OP_OR:   w_alu = r_dst_val | w_src_now;
      OP_XOR:  w_alu = r_dst_val ^ w_src_now;
      default: w_alu = r_dst_val & w_src_now;
    endcase
  end

  // Sequencer: operand snapshot, fixed read slots, compute, padding, commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_op      <= 2'd0;
      r_dst_sel <= 2'd0;
      r_src_sel <= 2'd0;
      r_src_imm <= 1'b0;
      r_imm     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_dst_val <= '0;
      r_result  <= '0;
    end else if (clk_en) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_dst_sel <= dst_sel;
            r_src_sel <= src_sel;
            r_src_imm <= src_imm;
            r_imm     <= imm;
            r_a       <= a_in;
            r_b       <= b_in;
            r_x       <= x_in;
            r_y       <= y_in;
            r_cnt     <= 4'd1;
            r_state   <= ST_RD_DST;
          end
        end
        ST_RD_DST: begin
          r_cnt   <= w_next_cnt;
          r_state <= ST_RD_SRC;
        end
        ST_RD_SRC: begin
          r_dst_val <= w_dst_now;
          r_cnt     <= w_next_cnt;
          r_state   <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          r_result <= w_alu;
          r_cnt    <= w_next_cnt;
          r_state  <= (w_next_cnt == LAST_CNT) ? ST_COMMIT : ST_PAD;
        end
        ST_PAD: begin
          r_cnt <= w_next_cnt;
          if (w_next_cnt == LAST_CNT) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_cnt   <= 4'd0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= 4'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes and data decoded from state; every output is 0 in IDLE.
  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    a_we      = 1'b0;
    b_we      = 1'b0;
    reg_wdata = '0;
    zero_we   = 1'b0;
    zero_out  = 1'b0;
    done      = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_RD_DST: begin
        if (w_dst_mem) begin
          mem_rd   = 1'b1;
          mem_addr = w_dst_addr;
        end
      end
      ST_RD_SRC: begin
        if (w_src_mem) begin
          mem_rd   = 1'b1;
          mem_addr = w_src_addr;
        end
      end
      ST_COMMIT: begin
        done     = 1'b1;
        zero_we  = 1'b1;
        zero_out = (r_result == '0);
        if (r_op != OP_FAN) begin
          if (w_dst_mem) begin
            mem_wr    = 1'b1;
            mem_addr  = w_dst_addr;
            mem_wdata = r_result;
          end else begin
            reg_wdata = r_result;
            a_we      = (r_dst_sel == SEL_A);
            b_we      = (r_dst_sel == SEL_B);
          end
        end
      end
      default: ;
    endcase
  end

`ifdef LOGIC_EXEC_OPCOUNT_EN
  logic [15:0] r_op_count;

  // Count enabled commits (FAN included), saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op_count <= 16'd0;
    end else if (clk_en && r_state == ST_COMMIT && r_op_count != 16'hFFFF) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: doc/logic_exec_unit.md
Name: logic_exec_unit

Overview:
- Multi-cycle executor for the CPU's nibble logical instructions: AND, OR, XOR, and the test-only FAN.
- Generalises the hard-wired XOR path. Width, cycle length and operation are all selectable.
- Operands are fetched from A, B, M(X), M(Y) or an immediate; the result is written back and Z is updated, all at a fixed cycle count.
- Sits beside the main ALU in the cpu, sharing the data-RAM port and register write strobes.

Parameters:
- DATA_WIDTH, 4: operand/result width in bits.
- ADDR_WIDTH, 12: RAM address width (X/Y width).
- CYCLES, 7: total enabled cycles per instruction, counting the start cycle. Legal range 5..15; out-of-range is a compile-time error via generate check.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- clk_en  in  1  cycle enable; all state advances only when high.
- start  in  1  begin operation; sampled in IDLE only.
- op  in  2  0=AND, 1=OR, 2=XOR, 3=FAN (AND, no writeback).
- dst_sel  in  2  r: 0=A, 1=B, 2=M(X), 3=M(Y).
- src_sel  in  2  q: same encoding as dst_sel.
- src_imm  in  1  1 = use imm instead of src_sel.
- imm  in  DATA_WIDTH  immediate operand.
- a_in, b_in  in  DATA_WIDTH  current A/B.
- x_in, y_in  in  ADDR_WIDTH  current X/Y.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_rd  out  1  read strobe; mem_rdata is valid on the next enabled cycle.
- mem_rdata  in  DATA_WIDTH  RAM read data.
- mem_wr  out  1  write strobe.
- mem_wdata  out  DATA_WIDTH  write data.
- a_we, b_we  out  1  register write strobes.
- reg_wdata  out  DATA_WIDTH  register write data.
- zero_we  out  1  Z flag update strobe.
- zero_out  out  1  new Z value.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset_n low at an edge): state=IDLE. All outputs are 0: strobes, busy, done, mem_addr, mem_wdata, reg_wdata, zero_out. No write occurs even if reset lands mid-operation. There is no carry port; C is never touched.
- Cycle counter cnt: 0 at start acceptance, +1 per enabled edge while busy.
- clk_en low freezes all state. Strobes hold their values, but writes must be qualified with clk_en by the consumer.
- States: IDLE -> RD_DST -> RD_SRC -> COMPUTE -> PAD -> COMMIT -> IDLE.
- IDLE: when start && clk_en, latch op, sel, imm, a_in, b_in, x_in, y_in. busy=1 from the next cycle.
- RD_DST (cnt=1): if dst is memory, mem_rd=1 and mem_addr=X or Y; otherwise use the latched register.
- RD_SRC (cnt=2):
  - capture the dst operand;
  - if src is memory and not immediate, issue the read.
- COMPUTE (cnt=3): capture src; result = dst op src over the full DATA_WIDTH (no carry, no width growth).
- PAD: idle until cnt=CYCLES-1. Skipped when CYCLES=5.
- COMMIT (cnt=CYCLES-1): done=1, zero_we=1, zero_out=(result==0). Writeback strobe depends on dst:
  - dst=A: a_we=1;
  - dst=B: b_we=1;
  - dst=M(X) or M(Y): mem_wr=1, with mem_addr and mem_wdata=result.
- FAN: no writeback strobe; Z is still updated.
- busy drops and state returns to IDLE on the next enabled edge.
- Read slots are fixed regardless of operand type, so cycle length is exactly CYCLES for every operand mix.
- X==Y with both operands in memory: two reads of the same address; the result is written to that address.
- dst==src register: XOR yields 0 (Z=1); AND/OR yields the operand unchanged.
- Operands are snapshots taken at start. Changes to a_in, b_in, x_in, y_in while busy are ignored.
- start while busy is ignored (not queued).
- start in the cycle after COMMIT is accepted, giving back-to-back operation with no gap.

Optional Feature:
- Macro: LOGIC_EXEC_OPCOUNT_EN.
- Defined: adds output op_count (16 bits).
  - Reset to 0.
  - Increments on each COMMIT with clk_en, FAN included.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Setup for all cases: A=1, B=F, M(X)=7, M(Y)=7, X!=Y.
- XOR A,B, CYCLES=7 -> a_we with reg_wdata=E at cnt 6. done exactly 7 enabled cycles after start. zero_out=0. mem_wr never high. B, X, Y, RAM unchanged.
- XOR M(X),M(Y) -> mem_wr at addr X, data 0. zero_out=1. M(Y) stays 7. a_we and b_we stay low.
- XOR B,imm=1 -> b_we with reg_wdata=E. Same sweep for AND: result 1. OR: result F. All of these with cycle length 7.
- FAN A,imm=0 -> no a_we, b_we or mem_wr. zero_we=1 with zero_out=1. Then CYCLES=5 build: done at the 5th cycle.
- Stall and reset:
  - XOR A,B with clk_en low for 3 cycles mid-op -> done after 7 enabled cycles, result E.
  - Repeat with reset_n low at cnt=4 -> no writes, busy=0, idle next cycle.
- Start handling:
  - start asserted every cycle during an op -> exactly one commit;
  - start at the cycle after done -> second op commits 7 cycles later;
  - with LOGIC_EXEC_OPCOUNT_EN, op_count=2.
